adder_axil_slave: RTL and testbench

ADDER_AXIL_SLAVE -- requirements
Module: adder_axil_slave

---
 rtl/adder_axil_slave_if.sv | 52 +++++
 rtl/adder_axil_slave.sv | 191 +++++++++++++++++++
 tb/tb_adder_axil_slave.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_axil_slave_if.sv
// AXI4-Lite bus bundle for the bit-serial adder slave. Signal names follow
// the s00_axi_* port naming the block is integrated with.
interface adder_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr;
  logic [2:0]                        s00_axi_awprot;
  logic                              s00_axi_awvalid;
  logic                              s00_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb;
  logic                              s00_axi_wvalid;
  logic                              s00_axi_wready;
  logic [1:0]                        s00_axi_bresp;
  logic                              s00_axi_bvalid;
  logic                              s00_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr;
  logic [2:0]                        s00_axi_arprot;
  logic                              s00_axi_arvalid;
  logic                              s00_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata;
  logic [1:0]                        s00_axi_rresp;
  logic                              s00_axi_rvalid;
  logic                              s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );
endinterface

// File: rtl/adder_axil_slave.sv
// AXI4-Lite slave wrapping a 32-bit bit-serial adder.
// Map: 0x0 OPA, 0x4 OPB, 0x8 CTRL (cin/start/busy/done/cout), 0xC SUM (RO).
// A start snapshots the operands into shift registers, so the programmer may
// reload OPA/OPB/cin while an add is running without disturbing it.
module adder_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_aresetn,
  adder_axil_slave_if.slave   s_axi,
  output logic                irq_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t state, state_nxt;

  logic [C_S_AXI_DATA_WIDTH-1:0] opa, opb, sum;
  logic                          cin, cout;
  logic [C_S_AXI_DATA_WIDTH-1:0] sh_a, sh_b, sh_res;
  logic                          sh_c;
  logic [4:0]                    cnt;

  logic                          aw_w_ready;
  logic                          bvalid;
  logic [1:0]                    bresp;
  logic                          arready;
  logic                          rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;

  logic       wr_en, rd_en;
  logic [1:0] wr_sel, rd_sel;
  logic       start_req, start_go, last_bit;
  logic       bit_sum, bit_carry;
  logic       busy, done;
  logic       unused_ok;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign wr_en  = aw_w_ready && s_axi.s00_axi_awvalid && s_axi.s00_axi_wvalid;
  assign rd_en  = arready && s_axi.s00_axi_arvalid;
  assign wr_sel = s_axi.s00_axi_awaddr[3:2];
  assign rd_sel = s_axi.s00_axi_araddr[3:2];

  // A start request is any accepted CTRL write with start=1 in byte lane 0;
  // it only launches an add when no add is in flight.
  assign start_req = wr_en && (wr_sel == 2'd2) && s_axi.s00_axi_wstrb[0] &&
                     s_axi.s00_axi_wdata[1];
  assign start_go  = start_req && (state != ST_RUN);
  assign last_bit  = (state == ST_RUN) && (cnt == 5'd31);

  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign irq_done = done;

  // One full-adder slice, LSB of the shift registers
  assign bit_sum   = sh_a[0] ^ sh_b[0] ^ sh_c;
  assign bit_carry = (sh_a[0] & sh_b[0]) | (sh_a[0] & sh_c) | (sh_b[0] & sh_c);

  assign s_axi.s00_axi_awready = aw_w_ready;
  assign s_axi.s00_axi_wready  = aw_w_ready;
  assign s_axi.s00_axi_bvalid  = bvalid;
  assign s_axi.s00_axi_bresp   = bresp;
  assign s_axi.s00_axi_arready = arready;
  assign s_axi.s00_axi_rvalid  = rvalid;
  assign s_axi.s00_axi_rdata   = rdata;
  assign s_axi.s00_axi_rresp   = 2'b00;

  assign unused_ok = ^{s_axi.s00_axi_awprot, s_axi.s00_axi_arprot,
                       s_axi.s00_axi_awaddr[1:0], s_axi.s00_axi_araddr[1:0]};

  // FSM state register
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  // FSM next-state: start from IDLE/DONE, finish after the 32nd bit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_req) state_nxt = ST_RUN;
      ST_RUN:           if (cnt == 5'd31) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Serial datapath: snapshot on start, shift one bit per RUN cycle, commit at the end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_c   <= 1'b0;
      sh_res <= '0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (start_go) begin
      sh_a   <= opa;
      sh_b   <= opb;
      sh_c   <= s_axi.s00_axi_wdata[0];
      sh_res <= '0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      sh_c   <= bit_carry;
      sh_res <= {bit_sum, sh_res[C_S_AXI_DATA_WIDTH-1:1]};
      cnt    <= cnt + 5'd1;
      if (last_bit) begin
        sum  <= {bit_sum, sh_res[C_S_AXI_DATA_WIDTH-1:1]};
        cout <= bit_carry;
      end
    end
  end

  // Programmable registers with byte-lane masking; SUM is never written from the bus
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      opa <= '0;
      opb <= '0;
      cin <= 1'b0;
    end else if (wr_en) begin
      case (wr_sel)
        2'd0: opa <= apply_strb(opa, s_axi.s00_axi_wdata, s_axi.s00_axi_wstrb);
        2'd1: opb <= apply_strb(opb, s_axi.s00_axi_wdata, s_axi.s00_axi_wstrb);
        2'd2: if (s_axi.s00_axi_wstrb[0]) cin <= s_axi.s00_axi_wdata[0];
        default: ;
      endcase
    end
  end

  // Write channel: single-cycle AW/W ready, blocked while a response is pending
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_w_ready <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= 2'b00;
    end else begin
      aw_w_ready <= !aw_w_ready && s_axi.s00_axi_awvalid &&
                    s_axi.s00_axi_wvalid && !bvalid;
      if (wr_en) begin
        bvalid <= 1'b1;
        bresp  <= (wr_sel == 2'd3) ? 2'b10 : 2'b00;
      end else if (bvalid && s_axi.s00_axi_bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read data selection from the current (pre-update) register values
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      2'd0: rd_mux = opa;
      2'd1: rd_mux = opb;
      2'd2: rd_mux = {15'd0, cout, 6'd0, done, busy, 6'd0, 1'b0, cin};
      2'd3: rd_mux = sum;
      default: rd_mux = '0;
    endcase
  end

  // Read channel: single-cycle arready, registered rdata held until rready
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      arready <= !arready && s_axi.s00_axi_arvalid && !rvalid;
      if (rd_en) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
      end else if (rvalid && s_axi.s00_axi_rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_axil_slave.sv
// Bench for adder_axil_slave: directed scenarios plus randomized adds and
// byte-strobe writes, checked against a register-level reference model.
module tb_adder_axil_slave;

  logic clk;
  logic rst_n;
  logic irq_done;
  int   tests;
  int   fails;
  int   cyc;
  int   hs_count;
  int   wr_hs_cyc;

  // Reference model state
  logic [31:0] m_opa, m_opb, m_sum;
  logic        m_cin, m_cout;
  logic [31:0] p_sum;
  logic        p_cout;

  adder_axil_slave_if bus ();

  adder_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s_axi           (bus.slave),
    .irq_done        (irq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.s00_axi_awready && bus.s00_axi_awvalid &&
        bus.s00_axi_wready && bus.s00_axi_wvalid)
      hs_count <= hs_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = 32'h0;
    if (strb[0]) m = m | 32'h0000_00FF;
    if (strb[1]) m = m | 32'h0000_FF00;
    if (strb[2]) m = m | 32'h00FF_0000;
    if (strb[3]) m = m | 32'hFF00_0000;
    return (old_val & ~m) | (new_val & m);
  endfunction

  function automatic logic [31:0] ctrl_exp(input logic busy, input logic done,
                                           input logic co, input logic ci);
    return (32'(co) << 16) + (32'(done) << 9) + (32'(busy) << 8) + 32'(ci);
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    bus.s00_axi_awaddr  = addr;
    bus.s00_axi_awprot  = 3'b000;
    bus.s00_axi_wdata   = data;
    bus.s00_axi_wstrb   = strb;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wvalid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.s00_axi_awready && n < 50) begin @(negedge clk); n++; end
    check("aw_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1;
    wr_hs_cyc = cyc;
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    bus.s00_axi_bready  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.s00_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    check("b_timeout", 32'(n >= 50), 32'd0);
    resp = bus.s00_axi_bresp;
    @(posedge clk); #1;
    bus.s00_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    bus.s00_axi_araddr  = addr;
    bus.s00_axi_arprot  = 3'b000;
    bus.s00_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.s00_axi_arready && n < 50) begin @(negedge clk); n++; end
    check("ar_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1;
    bus.s00_axi_arvalid = 1'b0;
    bus.s00_axi_rready  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.s00_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    check("r_timeout", 32'(n >= 50), 32'd0);
    data = bus.s00_axi_rdata;
    check("rresp", 32'(bus.s00_axi_rresp), 32'd0);
    @(posedge clk); #1;
    bus.s00_axi_rready = 1'b0;
  endtask

  // Waits for irq_done; returns cycles elapsed since the last write handshake
  task automatic wait_done(output int dly);
    int n;
    n = 0;
    @(negedge clk);
    while (!irq_done && n < 100) begin @(negedge clk); n++; end
    check("done_timeout", 32'(n >= 100), 32'd0);
    dly = cyc - wr_hs_cyc;
  endtask

  // Model of a start: result becomes visible only when done is reached
  task automatic model_start(input logic ci);
    logic [32:0] full;
    m_cin  = ci;
    full   = {1'b0, m_opa} + {1'b0, m_opb} + 33'(ci);
    p_sum  = full[31:0];
    p_cout = full[32];
  endtask

  task automatic model_reset();
    m_opa = 0; m_opb = 0; m_sum = 0; m_cin = 0; m_cout = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 32'({bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_bvalid,
                              bus.s00_axi_arready, bus.s00_axi_rvalid, irq_done}), 32'd0);
    check({tag, "_resp"}, 32'({bus.s00_axi_bresp, bus.s00_axi_rresp}), 32'd0);
    check({tag, "_rdata"}, bus.s00_axi_rdata, 32'd0);
  endtask

  task automatic check_regs(input string tag, input logic busy, input logic done);
    logic [31:0] d;
    axi_read(4'h0, d); check({tag, "_opa"}, d, m_opa);
    axi_read(4'h4, d); check({tag, "_opb"}, d, m_opb);
    axi_read(4'h8, d); check({tag, "_ctrl"}, d, ctrl_exp(busy, done, m_cout, m_cin));
    axi_read(4'hC, d); check({tag, "_sum"}, d, m_sum);
  endtask

  task automatic run_add(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci);
    logic [1:0]  r;
    int          dly;
    axi_write(4'h0, a, 4'hF, r); m_opa = a;
    axi_write(4'h4, b, 4'hF, r); m_opb = b;
    axi_write(4'h8, 32'h2 | 32'(ci), 4'h1, r);
    model_start(ci);
    check({tag, "_bresp"}, 32'(r), 32'd0);
    wait_done(dly);
    check({tag, "_latency_ok"}, 32'(dly <= 33), 32'd1);
    m_sum = p_sum; m_cout = p_cout;
    check_regs(tag, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] d, d2, a, b, v;
    logic [3:0]  s;
    logic [1:0]  r;
    logic        ci;
    int          dly;
    tests = 0; fails = 0; cyc = 0; hs_count = 0; wr_hs_cyc = 0;
    rst_n = 1'b0;
    bus.s00_axi_awaddr = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wdata = '0; bus.s00_axi_wstrb = '0; bus.s00_axi_wvalid = 1'b0;
    bus.s00_axi_bready = 1'b0; bus.s00_axi_araddr = '0; bus.s00_axi_arprot = '0;
    bus.s00_axi_arvalid = 1'b0; bus.s00_axi_rready = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_regs("post_reset", 1'b0, 1'b0);

    // Basic add with busy polled during the run
    axi_write(4'h0, 32'h1, 4'hF, r); m_opa = 32'h1;
    axi_write(4'h4, 32'h2, 4'hF, r); m_opb = 32'h2;
    axi_write(4'h8, 32'h2, 4'hF, r); model_start(1'b0);
    axi_read(4'h8, d);
    check("basic_busy", d, ctrl_exp(1'b1, 1'b0, m_cout, m_cin));
    wait_done(dly);
    check("basic_latency_ok", 32'(dly <= 33), 32'd1);
    check("basic_irq", 32'(irq_done), 32'd1);
    m_sum = p_sum; m_cout = p_cout;
    check_regs("basic", 1'b0, 1'b1);

    // Carry-out cases
    run_add("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0);
    run_add("wrap_cin", 32'hFFFF_FFFF, 32'h0, 1'b1);

    // Byte strobes and the read-only SUM slot
    axi_write(4'h0, 32'h0, 4'hF, r); m_opa = 32'h0;
    axi_write(4'h0, 32'h1234_5678, 4'b0011, r);
    m_opa = strb_merge(m_opa, 32'h1234_5678, 4'b0011);
    axi_read(4'h0, d); check("strb_opa", d, 32'h0000_5678);
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, r);
    check("sum_wr_bresp", 32'(r), 32'h2);
    axi_read(4'hC, d); check("sum_wr_unchanged", d, m_sum);

    // Register writes and a second start during RUN
    axi_write(4'h0, 32'h0000_1000, 4'hF, r); m_opa = 32'h0000_1000;
    axi_write(4'h4, 32'h0000_0234, 4'hF, r); m_opb = 32'h0000_0234;
    axi_write(4'h8, 32'h2, 4'h1, r); model_start(1'b0);
    d2 = wr_hs_cyc;
    axi_read(4'hC, d); check("run_sum_old", d, m_sum);
    repeat (5) @(posedge clk); #1;
    axi_write(4'h0, 32'h5, 4'hF, r); m_opa = 32'h5;
    axi_write(4'h8, 32'h3, 4'h1, r); m_cin = 1'b1;
    check("run_start_bresp", 32'(r), 32'd0);
    wr_hs_cyc = int'(d2);
    wait_done(dly);
    check("run_latency_ok", 32'(dly <= 33), 32'd1);
    m_sum = p_sum; m_cout = p_cout;
    check_regs("run_upd", 1'b0, 1'b1);

    // Back-pressure on the write response
    v = hs_count;
    bus.s00_axi_awaddr = 4'h4; bus.s00_axi_wdata = 32'hAAAA_5555; bus.s00_axi_wstrb = 4'hF;
    bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1; bus.s00_axi_bready = 1'b0;
    dly = 0;
    @(negedge clk);
    while (!bus.s00_axi_bvalid && dly < 50) begin @(negedge clk); dly++; end
    check("bp_b_timeout", 32'(dly >= 50), 32'd0);
    bus.s00_axi_wdata = 32'h0BAD_F00D;
    repeat (5) @(negedge clk);
    check("bp_awready_held", 32'({bus.s00_axi_awready, bus.s00_axi_wready}), 32'd0);
    check("bp_bvalid_held", 32'(bus.s00_axi_bvalid), 32'd1);
    bus.s00_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s00_axi_bready = 1'b0; bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0;
    @(negedge clk);
    check("bp_one_write", 32'(hs_count) - v, 32'd1);
    m_opb = 32'hAAAA_5555;
    axi_read(4'h4, d); check("bp_opb", d, m_opb);

    // Independent read and write in parallel
    fork
      axi_write(4'h0, 32'hCAFE_0001, 4'hF, r);
      axi_read(4'h4, d);
    join
    m_opa = 32'hCAFE_0001;
    check("par_read", d, m_opb);
    axi_read(4'h0, d); check("par_write", d, m_opa);

    // Reset in the middle of an add
    axi_write(4'h8, 32'h2, 4'h1, r); model_start(1'b0);
    repeat (7) @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_regs("after_reset", 1'b0, 1'b0);
    run_add("fresh", 32'h7, 32'h8, 1'b0);
    check("fresh_sum_value", m_sum, 32'hF);

    // Randomized adds and strobe writes
    for (int k = 0; k < 6; k++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(0, 1));
      run_add("rand_add", a, b, ci);
      s = 4'($urandom_range(0, 15));
      v = $urandom;
      axi_write(4'h4, v, s, r);
      m_opb = strb_merge(m_opb, v, s);
      axi_read(4'h4, d); check("rand_strb", d, m_opb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
